// File: rtl/oled_pkg.sv
// Shared opcodes, reset defaults and parser state for the OLED SPI link receiver.
package oled_pkg;

  localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
  localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
  localparam logic [7:0] CMD_CONTRAST    = 8'h81;
  localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
  localparam logic [7:0] CMD_SEG_REMAP0  = 8'hA0;
  localparam logic [7:0] CMD_SEG_REMAP1  = 8'hA1;
  localparam logic [7:0] CMD_COM_SCAN0   = 8'hC0;
  localparam logic [7:0] CMD_COM_SCAN1   = 8'hC8;
  localparam logic [7:0] CMD_INVERT0     = 8'hA6;
  localparam logic [7:0] CMD_INVERT1     = 8'hA7;

  localparam logic [7:0] RST_PRECHARGE   = 8'h22;
  localparam logic [7:0] RST_CONTRAST    = 8'h7F;
  localparam logic [7:0] RST_COM_PINS    = 8'h12;

  typedef enum logic [0:0] {
    ST_OPCODE = 1'b0,
    ST_ARG    = 1'b1
  } parse_state_e;

endpackage

// File: rtl/oled_spi_rx_deser.sv
// Synchronises the raw SPI pins, detects qualified sclk rises and assembles
// MSB-first bytes, emitting a one-cycle byte strobe together with the dc bit.
module oled_spi_rx_deser
  import oled_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs_i,
  input  logic       sdin_i,
  input  logic       sclk_i,
  input  logic       dc_i,
  input  logic       res_i,
  output logic       res_n_o,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       byte_dc_o
);

  // Bit order {res, dc, sclk, sdin, cs}; idle values keep cs and res deasserted.
  localparam logic [4:0] SYNC_RST = 5'b10001;

  logic [4:0] sync_q [SYNC_STAGES];
  logic       cs_s, sdin_s, sclk_s, dc_s, res_s, rise_s;
  logic       sclk_prev_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       dc_q, dc_d;
  logic       byte_valid_q, byte_valid_d;

  assign cs_s   = sync_q[SYNC_STAGES-1][0];
  assign sdin_s = sync_q[SYNC_STAGES-1][1];
  assign sclk_s = sync_q[SYNC_STAGES-1][2];
  assign dc_s   = sync_q[SYNC_STAGES-1][3];
  assign res_s  = sync_q[SYNC_STAGES-1][4];
  assign rise_s = sclk_s & ~sclk_prev_q & ~cs_s;

  // Input synchroniser chains, all pins delayed equally so sdin/dc stay aligned with sclk.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {res_i, dc_i, sclk_i, sdin_i, cs_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Shift register, bit counter and completed-byte capture.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_d       = byte_q;
    dc_d         = dc_q;
    byte_valid_d = 1'b0;
    if (!res_s || cs_s) begin
      bit_cnt_d = 3'd0;
      shift_d   = 8'h00;
    end else if (rise_s) begin
      shift_d   = {shift_q[6:0], sdin_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_d       = shift_d;
        dc_d         = dc_s;
      end else begin
        byte_valid_d = 1'b0;
      end
    end else begin
      bit_cnt_d = bit_cnt_q;
    end
  end

  // Deserialiser state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_prev_q  <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_q       <= 8'h00;
      dc_q         <= 1'b0;
      byte_valid_q <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_s;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_q       <= byte_d;
      dc_q         <= dc_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  assign res_n_o      = res_s;
  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign byte_dc_o    = dc_q;

endmodule

// File: rtl/oled_spi_rx.sv
// OLED SPI responder: splits received bytes into a data stream and a command
// parser that shadows panel configuration. OLED_SPI_RX_TRACE_EN adds a command trace port.
module oled_spi_rx
  import oled_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DCNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs,
  input  logic              sdin,
  input  logic              sclk,
  input  logic              dc,
  input  logic              res,
  input  logic              vbatc,
  input  logic              vddc,
  output logic              data_valid,
  output logic [7:0]        data_byte,
  output logic [DCNT_W-1:0] data_count,
  output logic              display_on,
  output logic              charge_pump,
  output logic [7:0]        precharge,
  output logic [7:0]        contrast,
  output logic [7:0]        com_pins,
  output logic              seg_remap,
  output logic              com_scan_rev,
  output logic              invert,
  output logic              unknown_cmd,
  output logic              panel_lit
`ifdef OLED_SPI_RX_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [7:0]        trace_opcode,
  output logic [7:0]        trace_arg
`endif
);

  logic       res_n_s, byte_valid_s, byte_dc_s;
  logic [7:0] byte_s;

  oled_spi_rx_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clock        (clock),
    .reset        (reset),
    .cs_i         (cs),
    .sdin_i       (sdin),
    .sclk_i       (sclk),
    .dc_i         (dc),
    .res_i        (res),
    .res_n_o      (res_n_s),
    .byte_valid_o (byte_valid_s),
    .byte_o       (byte_s),
    .byte_dc_o    (byte_dc_s)
  );

  parse_state_e      state_q, state_d;
  logic [7:0]        target_q, target_d;
  logic              data_valid_q, data_valid_d;
  logic [7:0]        data_byte_q, data_byte_d;
  logic [DCNT_W-1:0] data_count_q, data_count_d;
  logic              display_on_q, display_on_d;
  logic              charge_pump_q, charge_pump_d;
  logic [7:0]        precharge_q, precharge_d;
  logic [7:0]        contrast_q, contrast_d;
  logic [7:0]        com_pins_q, com_pins_d;
  logic              seg_remap_q, seg_remap_d;
  logic              com_scan_rev_q, com_scan_rev_d;
  logic              invert_q, invert_d;
  logic              unknown_cmd_q, unknown_cmd_d;
  logic              panel_lit_q, panel_lit_d;
`ifdef OLED_SPI_RX_TRACE_EN
  logic              trace_valid_q, trace_valid_d;
  logic [7:0]        trace_opcode_q, trace_opcode_d;
  logic [7:0]        trace_arg_q, trace_arg_d;
`endif

  // Parser next state and output register updates.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    data_valid_d   = 1'b0;
    data_byte_d    = data_byte_q;
    data_count_d   = data_count_q;
    display_on_d   = display_on_q;
    charge_pump_d  = charge_pump_q;
    precharge_d    = precharge_q;
    contrast_d     = contrast_q;
    com_pins_d     = com_pins_q;
    seg_remap_d    = seg_remap_q;
    com_scan_rev_d = com_scan_rev_q;
    invert_d       = invert_q;
    unknown_cmd_d  = 1'b0;
`ifdef OLED_SPI_RX_TRACE_EN
    trace_valid_d  = 1'b0;
    trace_opcode_d = trace_opcode_q;
    trace_arg_d    = trace_arg_q;
`endif
    if (!res_n_s) begin
      state_d        = ST_OPCODE;
      target_d       = 8'h00;
      data_byte_d    = 8'h00;
      data_count_d   = '0;
      display_on_d   = 1'b0;
      charge_pump_d  = 1'b0;
      precharge_d    = RST_PRECHARGE;
      contrast_d     = RST_CONTRAST;
      com_pins_d     = RST_COM_PINS;
      seg_remap_d    = 1'b0;
      com_scan_rev_d = 1'b0;
      invert_d       = 1'b0;
`ifdef OLED_SPI_RX_TRACE_EN
      trace_opcode_d = 8'h00;
      trace_arg_d    = 8'h00;
`endif
    end else if (byte_valid_s) begin
      if (byte_dc_s) begin
        data_valid_d = 1'b1;
        data_byte_d  = byte_s;
        data_count_d = data_count_q + {{(DCNT_W-1){1'b0}}, 1'b1};
      end else begin
        case (state_q)
          ST_OPCODE: begin
`ifdef OLED_SPI_RX_TRACE_EN
            trace_valid_d  = 1'b1;
            trace_opcode_d = byte_s;
            trace_arg_d    = 8'h00;
`endif
            case (byte_s)
              CMD_DISP_OFF:   display_on_d   = 1'b0;
              CMD_DISP_ON:    display_on_d   = 1'b1;
              CMD_SEG_REMAP0: seg_remap_d    = 1'b0;
              CMD_SEG_REMAP1: seg_remap_d    = 1'b1;
              CMD_COM_SCAN0:  com_scan_rev_d = 1'b0;
              CMD_COM_SCAN1:  com_scan_rev_d = 1'b1;
              CMD_INVERT0:    invert_d       = 1'b0;
              CMD_INVERT1:    invert_d       = 1'b1;
              CMD_CHARGE_PUMP, CMD_PRECHARGE, CMD_CONTRAST, CMD_COM_PINS: begin
                target_d = byte_s;
                state_d  = ST_ARG;
`ifdef OLED_SPI_RX_TRACE_EN
                trace_valid_d  = 1'b0;
                trace_opcode_d = trace_opcode_q;
`endif
              end
              default:        unknown_cmd_d  = 1'b1;
            endcase
          end
          ST_ARG: begin
            case (target_q)
              CMD_CHARGE_PUMP: charge_pump_d = byte_s[2];
              CMD_PRECHARGE:   precharge_d   = byte_s;
              CMD_CONTRAST:    contrast_d    = byte_s;
              CMD_COM_PINS:    com_pins_d    = byte_s;
              default:         target_d      = target_q;
            endcase
            state_d = ST_OPCODE;
`ifdef OLED_SPI_RX_TRACE_EN
            trace_valid_d  = 1'b1;
            trace_opcode_d = target_q;
            trace_arg_d    = byte_s;
`endif
          end
          default: state_d = ST_OPCODE;
        endcase
      end
    end else begin
      state_d = state_q;
    end
    // Power rails come straight from the pins; they never influence decoding.
    panel_lit_d = display_on_d & charge_pump_d & ~vddc & ~vbatc;
  end

  // Parser and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_OPCODE;
      target_q       <= 8'h00;
      data_valid_q   <= 1'b0;
      data_byte_q    <= 8'h00;
      data_count_q   <= '0;
      display_on_q   <= 1'b0;
      charge_pump_q  <= 1'b0;
      precharge_q    <= RST_PRECHARGE;
      contrast_q     <= RST_CONTRAST;
      com_pins_q     <= RST_COM_PINS;
      seg_remap_q    <= 1'b0;
      com_scan_rev_q <= 1'b0;
      invert_q       <= 1'b0;
      unknown_cmd_q  <= 1'b0;
      panel_lit_q    <= 1'b0;
`ifdef OLED_SPI_RX_TRACE_EN
      trace_valid_q  <= 1'b0;
      trace_opcode_q <= 8'h00;
      trace_arg_q    <= 8'h00;
`endif
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      data_valid_q   <= data_valid_d;
      data_byte_q    <= data_byte_d;
      data_count_q   <= data_count_d;
      display_on_q   <= display_on_d;
      charge_pump_q  <= charge_pump_d;
      precharge_q    <= precharge_d;
      contrast_q     <= contrast_d;
      com_pins_q     <= com_pins_d;
      seg_remap_q    <= seg_remap_d;
      com_scan_rev_q <= com_scan_rev_d;
      invert_q       <= invert_d;
      unknown_cmd_q  <= unknown_cmd_d;
      panel_lit_q    <= panel_lit_d;
`ifdef OLED_SPI_RX_TRACE_EN
      trace_valid_q  <= trace_valid_d;
      trace_opcode_q <= trace_opcode_d;
      trace_arg_q    <= trace_arg_d;
`endif
    end
  end

  assign data_valid   = data_valid_q;
  assign data_byte    = data_byte_q;
  assign data_count   = data_count_q;
  assign display_on   = display_on_q;
  assign charge_pump  = charge_pump_q;
  assign precharge    = precharge_q;
  assign contrast     = contrast_q;
  assign com_pins     = com_pins_q;
  assign seg_remap    = seg_remap_q;
  assign com_scan_rev = com_scan_rev_q;
  assign invert       = invert_q;
  assign unknown_cmd  = unknown_cmd_q;
  assign panel_lit    = panel_lit_q;
`ifdef OLED_SPI_RX_TRACE_EN
  assign trace_valid  = trace_valid_q;
  assign trace_opcode = trace_opcode_q;
  assign trace_arg    = trace_arg_q;
`endif

endmodule

// File: tb/tb_oled_spi_rx.sv
// Directed self-checking bench for oled_spi_rx; trace checks compile in with OLED_SPI_RX_TRACE_EN.
module tb_oled_spi_rx;

  logic        clock = 1'b0;
  logic        reset, cs, sdin, sclk, dc, res, vbatc, vddc;
  logic        data_valid, display_on, charge_pump, seg_remap, com_scan_rev, invert;
  logic        unknown_cmd, panel_lit;
  logic [7:0]  data_byte, precharge, contrast, com_pins;
  logic [15:0] data_count;
`ifdef OLED_SPI_RX_TRACE_EN
  logic        trace_valid;
  logic [7:0]  trace_opcode, trace_arg;
`endif

  int checks = 0;
  int failures = 0;

  int          dv_cnt = 0;
  int          unk_cnt = 0;
  int          rise_cnt = 0;
  int          trc_cnt = 0;
  logic [7:0]  db_hist [0:15];
  logic [7:0]  last_trc_op = 8'h00;
  logic [7:0]  last_trc_arg = 8'hFF;
  logic        disp_prev = 1'b0;
  int          base_dv, base_unk, base_rise, base_trc;

  oled_spi_rx dut (
    .clock(clock), .reset(reset), .cs(cs), .sdin(sdin), .sclk(sclk), .dc(dc),
    .res(res), .vbatc(vbatc), .vddc(vddc),
    .data_valid(data_valid), .data_byte(data_byte), .data_count(data_count),
    .display_on(display_on), .charge_pump(charge_pump), .precharge(precharge),
    .contrast(contrast), .com_pins(com_pins), .seg_remap(seg_remap),
    .com_scan_rev(com_scan_rev), .invert(invert), .unknown_cmd(unknown_cmd),
    .panel_lit(panel_lit)
`ifdef OLED_SPI_RX_TRACE_EN
    , .trace_valid(trace_valid), .trace_opcode(trace_opcode), .trace_arg(trace_arg)
`endif
  );

  always #5 clock = ~clock;

  // Pulse and edge monitor, sampled away from the active edge.
  always @(negedge clock) begin
    if (data_valid) begin
      db_hist[dv_cnt[3:0]] <= data_byte;
      dv_cnt <= dv_cnt + 1;
    end
    if (unknown_cmd) unk_cnt <= unk_cnt + 1;
    if (display_on && !disp_prev) rise_cnt <= rise_cnt + 1;
    disp_prev <= display_on;
`ifdef OLED_SPI_RX_TRACE_EN
    if (trace_valid) begin
      trc_cnt      <= trc_cnt + 1;
      last_trc_op  <= trace_opcode;
      last_trc_arg <= trace_arg;
    end
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input logic d);
    dc = d;
    for (int i = 0; i < n; i++) begin
      sdin = b[7-i];
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    send_bits(b, 8, d);
    #40;
  endtask

  initial begin
    reset = 1'b1; cs = 1'b1; sdin = 1'b0; sclk = 1'b0; dc = 1'b0;
    res = 1'b1; vbatc = 1'b1; vddc = 1'b1;
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    #100;
    check("rst_display_on", {31'd0, display_on}, 32'd0);
    check("rst_precharge", {24'd0, precharge}, 32'h22);
    check("rst_contrast", {24'd0, contrast}, 32'h7F);
    check("rst_com_pins", {24'd0, com_pins}, 32'h12);
    check("rst_data_count", {16'd0, data_count}, 32'd0);
    check("rst_data_byte", {24'd0, data_byte}, 32'd0);

    // Power-up command sequence
    cs = 1'b0;
    send_byte(8'hAE, 1'b0); send_byte(8'h8D, 1'b0); send_byte(8'h14, 1'b0);
    send_byte(8'hD9, 1'b0); send_byte(8'hF1, 1'b0); send_byte(8'hAF, 1'b0);
    #100;
    check("seq_display_on", {31'd0, display_on}, 32'd1);
    check("seq_charge_pump", {31'd0, charge_pump}, 32'd1);
    check("seq_precharge", {24'd0, precharge}, 32'hF1);
    check("seq_no_unknown", unk_cnt, 32'd0);
    check("seq_lit_rails_off", {31'd0, panel_lit}, 32'd0);

    // Remap / scan / COM pins with rails enabled
    vddc = 1'b0; vbatc = 1'b0;
    send_byte(8'hA1, 1'b0); send_byte(8'hC8, 1'b0);
    send_byte(8'hDA, 1'b0); send_byte(8'h20, 1'b0);
    #100;
    check("seg_remap", {31'd0, seg_remap}, 32'd1);
    check("com_scan_rev", {31'd0, com_scan_rev}, 32'd1);
    check("com_pins", {24'd0, com_pins}, 32'h20);
    check("panel_lit_on", {31'd0, panel_lit}, 32'd1);
    vbatc = 1'b1;
    #50;
    check("panel_lit_vbat_off", {31'd0, panel_lit}, 32'd0);

    // Partial AF aborted by cs, then a full AE
    send_byte(8'hAE, 1'b0);
    #100;
    check("disp_off_before_abort", {31'd0, display_on}, 32'd0);
    base_rise = rise_cnt; base_unk = unk_cnt;
    send_bits(8'hAF, 5, 1'b0);
    #40 cs = 1'b1;
    #200 cs = 1'b0;
    #100;
    send_byte(8'hAE, 1'b0);
    #100;
    check("abort_display_off", {31'd0, display_on}, 32'd0);
    check("abort_no_disp_rise", rise_cnt - base_rise, 32'd0);
    check("abort_no_unknown", unk_cnt - base_unk, 32'd0);

    // Data bytes
    base_dv = dv_cnt;
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1);
    #100;
    check("data_pulses", dv_cnt - base_dv, 32'd2);
    check("data_first", {24'd0, db_hist[base_dv[3:0]]}, 32'h55);
    check("data_second", {24'd0, db_hist[base_dv[3:0] + 4'd1]}, 32'hAA);
    check("data_count_2", {16'd0, data_count}, 32'd2);
    check("data_cfg_contrast", {24'd0, contrast}, 32'h7F);
    check("data_cfg_com_pins", {24'd0, com_pins}, 32'h20);

    // Data byte interleaved between opcode and argument
    base_dv = dv_cnt;
    send_byte(8'h81, 1'b0); send_byte(8'h3C, 1'b1);
    #100;
    check("arg_pending_contrast", {24'd0, contrast}, 32'h7F);
    send_byte(8'h9F, 1'b0);
    #100;
    check("interleave_pulses", dv_cnt - base_dv, 32'd1);
    check("interleave_data", {24'd0, data_byte}, 32'h3C);
    check("interleave_contrast", {24'd0, contrast}, 32'h9F);
    check("data_count_3", {16'd0, data_count}, 32'd3);

    // Unknown opcode, then res low
    send_byte(8'hA7, 1'b0);
    #100;
    check("invert_set", {31'd0, invert}, 32'd1);
    base_unk = unk_cnt; base_trc = trc_cnt;
    send_byte(8'hE3, 1'b0);
    #100;
    check("unknown_pulse", unk_cnt - base_unk, 32'd1);
`ifdef OLED_SPI_RX_TRACE_EN
    check("trace_pulse", trc_cnt - base_trc, 32'd1);
    check("trace_opcode", {24'd0, last_trc_op}, 32'hE3);
    check("trace_arg", {24'd0, last_trc_arg}, 32'h00);
`endif
    vbatc = 1'b0;
    res = 1'b0;
    #320 res = 1'b1;
    #100;
    check("res_display_on", {31'd0, display_on}, 32'd0);
    check("res_charge_pump", {31'd0, charge_pump}, 32'd0);
    check("res_precharge", {24'd0, precharge}, 32'h22);
    check("res_contrast", {24'd0, contrast}, 32'h7F);
    check("res_com_pins", {24'd0, com_pins}, 32'h12);
    check("res_seg_remap", {31'd0, seg_remap}, 32'd0);
    check("res_com_scan", {31'd0, com_scan_rev}, 32'd0);
    check("res_invert", {31'd0, invert}, 32'd0);
    check("res_data_count", {16'd0, data_count}, 32'd0);
    check("res_data_byte", {24'd0, data_byte}, 32'd0);
    check("res_panel_lit", {31'd0, panel_lit}, 32'd0);

    // Parser restarts in OPCODE after res: 8D 14 AF lights the panel again
    send_byte(8'h8D, 1'b0); send_byte(8'h14, 1'b0); send_byte(8'hAF, 1'b0);
    #100;
    check("post_res_panel_lit", {31'd0, panel_lit}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oled_spi_rx.md
Name: oled_spi_rx

Overview:
- SPI responder and command decoder for the 4-wire, write-only OLED panel link (cs, sdin, sclk, dc) plus the res, vbatc and vddc control lines.
- Oversamples the link on the system clock, deserialises bytes MSB first, and splits them by dc into command bytes and data bytes.
- Parses single- and two-byte display commands into a shadow copy of panel configuration and exposes the data-byte stream.
- Used as a panel model in simulation and as a link monitor on the debug bus.

Parameters:
- SYNC_STAGES, 2, flops per input synchroniser for cs/sdin/sclk/dc/res; minimum 2.
- DCNT_W, 16, width of the data-byte counter.

Ports:
- clock  in  1  system clock; must be at least 4x the sclk rate
- reset  in  1  synchronous, active-high
- cs  in  1  chip select, active-low
- sdin  in  1  serial data, MSB first, sampled on sclk rising edge
- sclk  in  1  serial clock
- dc  in  1  0 = command byte, 1 = data byte; sampled with the 8th bit
- res  in  1  panel reset, active-low
- vbatc  in  1  VBAT enable, active-low
- vddc  in  1  VDD enable, active-low
- data_valid  out  1  one-cycle strobe, data byte received
- data_byte  out  8  received data byte
- data_count  out  DCNT_W  data bytes received since reset or res-low; wraps modulo 2^DCNT_W
- display_on  out  1  set by AF, cleared by AE
- charge_pump  out  1  bit 2 of the 8D argument
- precharge  out  8  D9 argument
- contrast  out  8  81 argument
- com_pins  out  8  DA argument
- seg_remap  out  1  A1 = 1, A0 = 0
- com_scan_rev  out  1  C8 = 1, C0 = 0
- invert  out  1  A7 = 1, A6 = 0
- unknown_cmd  out  1  one-cycle strobe on an undecoded opcode
- panel_lit  out  1  display_on & charge_pump & !vddc & !vbatc

Behaviour:
- Clock and reset: clock is clock; reset is synchronous, active-high.
- Reset values:
  - display_on, charge_pump, seg_remap, com_scan_rev, invert, data_valid, unknown_cmd = 0
  - data_byte = 0, data_count = 0
  - precharge = 8'h22, contrast = 8'h7F, com_pins = 8'h12
  - parser in OPCODE, bit counter = 0
- Sampling: every input passes through SYNC_STAGES flops. A sclk rising edge is detected when the synchronised sclk goes 0 to 1 while synchronised cs = 0. On each detected edge, shift in sdin and increment the 3-bit bit counter.
- Byte completion: when the 8th edge is detected, the assembled byte and the current dc are registered. Strobes and register updates appear on the next clock. Latency from the raw 8th sclk rise is SYNC_STAGES + 2 clocks.
- cs high: clears the bit counter and discards any partial byte. Parser state is kept, so an argument may arrive in a later cs frame.
- Data bytes (dc = 1): pulse data_valid for one cycle, update data_byte, increment data_count. The parser is unaffected.
- Parser FSM (command bytes only):
  - OPCODE state:
    - AE/AF/A0/A1/A6/A7/C0/C8 update their output immediately and stay in OPCODE.
    - 8D/D9/81/DA latch the opcode and go to ARG.
    - Any other opcode pulses unknown_cmd and stays in OPCODE.
  - ARG state: the next command byte is the argument. Write it to the latched target (charge_pump <= arg[2]), then return to OPCODE.
  - A data byte received while in ARG is still emitted as data; the parser stays in ARG.
- res low (synchronised): same effect as reset on every output and all state, including data_count. Bytes are ignored while res = 0.
- reset or res mid-byte: the partial byte is discarded; there is no strobe.
- Power inputs never gate decoding; they only affect panel_lit.

Optional Feature:
- Macro: OLED_SPI_RX_TRACE_EN.
- When defined, three extra ports are added:
  - trace_valid (out, 1): one-cycle strobe per completed command.
  - trace_opcode (out, 8).
  - trace_arg (out, 8): 0 for single-byte commands.
- trace_valid fires in the same cycle the output register updates, and also for unknown opcodes.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package oled_pkg:
  - Opcode constants: CMD_DISP_OFF=8'hAE, CMD_DISP_ON=8'hAF, CMD_CHARGE_PUMP=8'h8D, CMD_PRECHARGE=8'hD9, CMD_CONTRAST=8'h81, CMD_COM_PINS=8'hDA, CMD_SEG_REMAP0/1, CMD_COM_SCAN0/1, CMD_INVERT0/1.
  - Reset-default constants.
  - Parser state enum.
- One natural sub-module: oled_spi_rx_deser (synchronisers, edge detect, bit counter, byte/dc strobe). The parser stays in the top module.

Test Plan:
- Reset, then cs=0 and send command bytes AE, 8D, 14, D9, F1, AF -> display_on=1, charge_pump=1, precharge=8'hF1, no unknown_cmd.
- With vddc=0 and vbatc=0, send A1, C8, DA, 20 -> seg_remap=1, com_scan_rev=1, com_pins=8'h20, panel_lit=1; then set vbatc=1 -> panel_lit=0.
- Raise cs after 5 bits of 8'hAF, then send a full AE -> display_on stays 0 throughout; exactly one command is decoded.
- With dc=1, send 8'h55 then 8'hAA -> two data_valid pulses, data_byte 55 then AA, data_count=2; config outputs unchanged.
- Send 81 as a command, then data byte 3C with dc=1, then 9F as a command -> data_valid with 3C, contrast=8'h9F.
- Send opcode 8'hE3 -> one unknown_cmd pulse. Then pull res low for 4 sclk periods -> all outputs return to their reset values and data_count=0. With OLED_SPI_RX_TRACE_EN defined, the E3 also produces trace_valid with trace_opcode=8'hE3 and trace_arg=0.
